// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and loader state encoding
// for the instruction-memory image loader.
package imem_pkg;

    localparam int IMEM_DEPTH = 1024;
    localparam int WORD_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } ld_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles four stream bytes into one
// little-endian word; word_full marks the completing byte.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [7:0]        din,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [WORD_W-1:0] sr;
    logic [1:0]        idx;

    // Bytes enter at the top so byte 0 ends up in bits [7:0].
    assign word      = {din, sr[WORD_W-1:8]};
    assign word_full = push && (idx == 2'd3);

    // Shift register and byte index; index wraps after each word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            idx <= '0;
        end else if (clear) begin
            sr  <= '0;
            idx <= '0;
        end else if (push) begin
            sr  <= word;
            idx <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a length-prefixed byte image into imem
// and holds the core in reset until done. Macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        core_rst_n
);

    ld_state_t         state_q;
    ld_state_t         state_d;
    logic [7:0]        len_lo;
    logic              len_hi;
    logic [CNT_W-1:0]  nwords;
    logic [CNT_W-1:0]  widx;
    logic [CNT_W-1:0]  hdr;
    logic              xfer;
    logic              push;
    logic              go;
    logic              bad_len;
    logic              last;
    logic [WORD_W-1:0] word;
    logic              word_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign byte_ready = (state_q == LEN) || (state_q == DATA)
                     || (state_q == CHK);
    assign busy       = byte_ready || (state_q == WRITE);
    assign mem_we     = (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign core_rst_n = done;

    assign xfer = byte_valid && byte_ready;
    assign push = xfer && (state_q == DATA);
    assign go   = start && ((state_q == IDLE) || (state_q == DONE)
                         || (state_q == ERR));

    assign hdr     = CNT_W'({byte_data, len_lo});
    assign bad_len = (hdr == '0) || (32'(hdr) > 32'(DEPTH));
    assign last    = (widx == nwords - CNT_W'(1));

    imem_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (go),
        .push      (push),
        .din       (byte_data),
        .word      (word),
        .word_full (word_full)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (go) state_d = LEN;
            end
            LEN: begin
                if (xfer && len_hi) state_d = bad_len ? ERR : DATA;
            end
            DATA: begin
                if (word_full) state_d = WRITE;
            end
            WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = last ? CHK : DATA;
`else
                state_d = last ? DONE : DATA;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) state_d = (byte_data == csum) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Header capture, word counter and memory write registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo    <= '0;
            len_hi    <= 1'b0;
            nwords    <= '0;
            widx      <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (go) begin
                len_hi <= 1'b0;
                widx   <= '0;
            end
            if (xfer && (state_q == LEN)) begin
                if (!len_hi) begin
                    len_lo <= byte_data;
                    len_hi <= 1'b1;
                end else begin
                    nwords <= hdr;
                end
            end
            if (word_full) begin
                mem_addr  <= 32'(widx) << 2;
                mem_wdata <= word;
            end
            if (state_q == WRITE) widx <= widx + CNT_W'(1);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR of data bytes, cleared at each start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    csum <= '0;
        else if (go)   csum <= '0;
        else if (push) csum <= csum ^ byte_data;
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader
// against a stream-parsing reference model.
module tb_imem_loader;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        core_rst_n;

    int n_cmp = 0;
    int n_bad = 0;
    int bubble_bad = 0;

    logic [7:0]  stim[$];
    logic [63:0] wq[$];
    logic [63:0] eq[$];
    bit          e_done;
    bit          e_err;

    imem_loader #(.DEPTH(1024), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .core_rst_n (core_rst_n)
    );

    always #5 clk = ~clk;

    // Record every memory write seen on the port.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wq.push_back({mem_addr, mem_wdata});
            if (byte_ready) bubble_bad++;
        end
    end

    // Reference: parse the byte stream by its format rules.
    task automatic model();
        int n;
        logic [7:0] x;
        eq.delete();
        e_done = 0;
        e_err = 0;
        n = int'(stim[0]) + 256 * int'(stim[1]);
        if (n == 0 || n > 1024) begin
            e_err = 1;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            eq.push_back({32'(w * 4), stim[2+4*w+3], stim[2+4*w+2],
                          stim[2+4*w+1], stim[2+4*w]});
            for (int b = 0; b < 4; b++) x ^= stim[2+4*w+b];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (stim[2+4*n] == x) e_done = 1;
        else e_err = 1;
`else
        e_done = 1;
`endif
    endtask

    task automatic make_image(input logic [31:0] w[$]);
        logic [7:0] x;
        x = 8'h00;
        stim.delete();
        stim.push_back(8'(w.size()));
        stim.push_back(8'(w.size() >> 8));
        foreach (w[i]) begin
            for (int b = 0; b < 4; b++) begin
                stim.push_back(w[i][8*b +: 8]);
                x ^= w[i][8*b +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(x);
`endif
    endtask

    function automatic int first_diff();
        if (wq.size() != eq.size()) return -2;
        foreach (wq[i]) if (wq[i] !== eq[i]) return i;
        return -1;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: always valid, 1: random valid, 2: alternate 1/0
    task automatic send(input int from, input int to, input int mode,
                        output bit tmo);
        int i;
        int g;
        i = from;
        g = 0;
        tmo = 0;
        while (i < to) begin
            @(negedge clk);
            if (g > 20000) begin
                tmo = 1;
                break;
            end
            g++;
            case (mode)
                0: byte_valid = 1'b1;
                1: byte_valid = 1'($urandom_range(0, 1));
                default: byte_valid = ~byte_valid;
            endcase
            byte_data = stim[i];
            if (byte_valid && byte_ready) i++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_end(output bit tmo);
        tmo = 1;
        for (int k = 0; k < 20; k++) begin
            if (done || error) begin
                tmo = 0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic load(input int mode, output bit tmo);
        bit t1;
        bit t2;
        wq.delete();
        pulse_start();
        send(0, stim.size(), mode, t1);
        wait_end(t2);
        tmo = t1 | t2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (byte_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_ready: got %b want 0", byte_ready);
        end
        n_cmp++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_we_busy: got %b%b want 00", mem_we, busy);
        end
        n_cmp++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mem: got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        n_cmp++;
        if ({done, error, core_rst_n} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_flags: got %b%b%b want 000",
                     done, error, core_rst_n);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit t1;
        bit t2;
        int d;
        make_image('{32'h00000013, 32'h00100093});
        eq.delete();
        eq.push_back({32'h0, 32'h00000013});
        eq.push_back({32'h4, 32'h00100093});
        wq.delete();
        pulse_start();
        n_cmp++;
        if (byte_ready !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_len_ready: got %b%b want 11", byte_ready, busy);
        end
        send(0, stim.size(), 0, t1);
        wait_end(t2);
        n_cmp++;
        if (t1 | t2) begin
            n_bad++;
            $display("FAIL basic_timeout: got 1 want 0");
        end
        d = first_diff();
        n_cmp++;
        if (d != -1) begin
            n_bad++;
            $display("FAIL basic_writes: diff at %0d, got %0d writes want 2",
                     d, wq.size());
        end
        n_cmp++;
        if ({done, error, core_rst_n} !== 3'b101) begin
            n_bad++;
            $display("FAIL basic_flags: got %b%b%b want 101",
                     done, error, core_rst_n);
        end
        n_cmp++;
        if (mem_addr !== 32'h4 || mem_wdata !== 32'h00100093) begin
            n_bad++;
            $display("FAIL basic_hold: got %h/%h want 4/00100093",
                     mem_addr, mem_wdata);
        end
    endtask

    task automatic test_bad_len();
        bit tmo;
        logic [7:0] hi[2];
        logic [7:0] lo[2];
        lo[0] = 8'h00; hi[0] = 8'h00;
        lo[1] = 8'h01; hi[1] = 8'h04;
        for (int k = 0; k < 2; k++) begin
            stim.delete();
            stim.push_back(lo[k]);
            stim.push_back(hi[k]);
            load(0, tmo);
            n_cmp++;
            if (tmo || {done, error, core_rst_n} !== 3'b010) begin
                n_bad++;
                $display("FAIL badlen_%0d: got tmo=%0d d/e/c=%b%b%b want 010",
                         k, tmo, done, error, core_rst_n);
            end
            n_cmp++;
            if (wq.size() != 0) begin
                n_bad++;
                $display("FAIL badlen_we_%0d: got %0d writes want 0",
                         k, wq.size());
            end
        end
    endtask

    task automatic test_toggle();
        bit tmo;
        make_image('{32'hDEADBEEF});
        model();
        bubble_bad = 0;
        byte_valid = 1'b0;
        load(2, tmo);
        n_cmp++;
        if (tmo || wq.size() != 1 || wq[0] !== {32'h0, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL toggle_write: got %0d writes first %h want 1 %h",
                     wq.size(), wq.size() ? wq[0] : 64'h0, eq[0]);
        end
        n_cmp++;
        if (bubble_bad != 0 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL toggle_bubble: got ready-in-write %0d done %b want 0 1",
                     bubble_bad, done);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bit tmo;
        logic [7:0] ck[2];
        ck[0] = 8'h22;
        ck[1] = 8'h23;
        for (int k = 0; k < 2; k++) begin
            stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
            stim.push_back(ck[k]);
            load(0, tmo);
            n_cmp++;
            if (tmo || done !== (k == 0) || error !== (k == 1)) begin
                n_bad++;
                $display("FAIL chk_%0d: got d/e %b%b want %b%b",
                         k, done, error, k == 0, k == 1);
            end
            n_cmp++;
            if (wq.size() != 1 || wq[0] !== {32'h0, 32'hDEADBEEF}) begin
                n_bad++;
                $display("FAIL chk_write_%0d: got %0d writes want 1",
                         k, wq.size());
            end
        end
    endtask
`endif

    task automatic test_abort();
        bit t1;
        bit tmo;
        int d;
        make_image('{32'h11223344, 32'h55667788});
        wq.delete();
        pulse_start();
        send(0, 6, 0, t1);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({byte_ready, mem_we, busy, done, error, core_rst_n} !== 6'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_rst: got r/we/b/d/e/c=%b%b%b%b%b%b %h/%h want 0",
                     byte_ready, mem_we, busy, done, error, core_rst_n,
                     mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model();
        load(0, tmo);
        d = first_diff();
        n_cmp++;
        if (tmo || d != -1 || done !== e_done) begin
            n_bad++;
            $display("FAIL abort_reload: got diff %0d done %b want -1 %b",
                     d, done, e_done);
        end
    endtask

    task automatic test_start_ignored();
        bit t1;
        bit t2;
        int d;
        make_image('{32'hA5A5_0F0F, 32'h0000_1234});
        model();
        wq.delete();
        pulse_start();
        send(0, 5, 0, t1);
        pulse_start();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_busy: got %b want 1", busy);
        end
        send(5, stim.size(), 0, t2);
        wait_end(t1);
        d = first_diff();
        n_cmp++;
        if (t1 || t2 || d != -1 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL start_ignored: got diff %0d done %b want -1 1",
                     d, done);
        end
    endtask

    task automatic test_back_to_back();
        bit tmo;
        int d;
        logic [31:0] w[$];
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_sticky: got %b want 1", done);
        end
        pulse_start();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1 || core_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_clear: got d/b/c %b%b%b want 010",
                     done, busy, core_rst_n);
        end
        for (int k = 0; k < 3; k++) w.push_back($urandom);
        make_image(w);
        model();
        wq.delete();
        send(0, stim.size(), 1, tmo);
        wait_end(tmo);
        d = first_diff();
        n_cmp++;
        if (tmo || d != -1 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_load: got diff %0d done %b want -1 1", d, done);
        end
    endtask

    task automatic test_random();
        bit tmo;
        int d;
        logic [31:0] w[$];
        for (int k = 0; k < 6; k++) begin
            w.delete();
            for (int j = 0; j < $urandom_range(1, 8); j++) w.push_back($urandom);
            make_image(w);
            if (k == 5) stim[stim.size()-1] = ~stim[stim.size()-1];
            model();
            load(1, tmo);
            d = first_diff();
            n_cmp++;
            if (tmo || d != -1 || done !== e_done || error !== e_err) begin
                n_bad++;
                $display("FAIL rand_%0d: got diff %0d d/e %b%b want -1 %b%b",
                         k, d, done, error, e_done, e_err);
            end
        end
    endtask

    task automatic test_max_depth();
        bit tmo;
        int d;
        logic [31:0] w[$];
        for (int j = 0; j < 1024; j++) w.push_back($urandom);
        make_image(w);
        model();
        load(0, tmo);
        d = first_diff();
        n_cmp++;
        if (tmo || d != -1 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL max_depth: got diff %0d writes %0d done %b want -1 1024 1",
                     d, wq.size(), done);
        end
        n_cmp++;
        if (mem_addr !== 32'hFFC) begin
            n_bad++;
            $display("FAIL max_addr: got %h want 00000ffc", mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_len();
        test_toggle();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_abort();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_max_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
